// File: rtl/toggle_mem_responder.sv
// Memory-side end of the toggle req/ack port: one 16-bit read or byte-masked write per request,
// served from a local block RAM after WAIT_CYCLES wait states.
module toggle_mem_responder #(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [22:1] mem_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_ds,
  input  logic [15:0] mem_din,
  input  logic        stall,
  output logic        mem_req_ack,
  output logic [15:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   we_q;
  logic [1:0]             ds_q;
  logic [15:0]            din_q;
  logic                   oor_q;
  logic                   oor_in;
  logic                   ram_go;
  logic [15:0]            rd_q;

  logic [7:0] ram_lo [2**ADDR_BITS];
  logic [7:0] ram_hi [2**ADDR_BITS];

  // Anything above the implemented word-address bits is out of range.
  assign oor_in = (mem_addr >> ADDR_BITS) != '0;

  // Reset is folded in so an access abandoned by reset never touches the RAM.
  assign ram_go = resetn && (state == S_ACCESS) && !stall;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      mem_req_ack <= 1'b0;
      mem_dout    <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req != mem_req_ack) begin
            addr_q <= mem_addr[ADDR_BITS:1];
            we_q   <= mem_we;
            ds_q   <= mem_ds;
            din_q  <= mem_din;
            oor_q  <= oor_in;
            busy   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= S_ACCESS;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!stall) begin
            if (cnt == 4'd0) state <= S_ACCESS;
            else             cnt   <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!stall) state <= S_DONE;
        end
        S_DONE: begin
          mem_req_ack <= ~mem_req_ack;
          if (!we_q) mem_dout <= oor_q ? 16'hFFFF : rd_q;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single-port, synchronous-read RAM as two byte banks.
  always_ff @(posedge clk) begin
    if (ram_go && we_q && !oor_q) begin
      if (ds_q[0]) ram_lo[addr_q] <= din_q[7:0];
      if (ds_q[1]) ram_hi[addr_q] <= din_q[15:8];
    end
    if (ram_go && !we_q) rd_q <= {ram_hi[addr_q], ram_lo[addr_q]};
  end

endmodule

// File: tb/tb_toggle_mem_responder.sv
// Directed bench for toggle_mem_responder with a transaction-level memory/timing model.
module tb_toggle_mem_responder;
  localparam int W  = 2;
  localparam int AB = 14;

  logic        clk = 1'b0;
  logic        resetn;
  logic [22:1] mem_addr;
  logic        mem_req, mem_we, stall;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic        mem_req_ack, busy;
  logic [15:0] mem_dout;

  logic [22:1] addr_z;
  logic        req_z, we_z, stall_z;
  logic [1:0]  ds_z;
  logic [15:0] din_z;
  logic        ack_z, busy_z;
  logic [15:0] dout_z;

  always #5 clk = ~clk;

  toggle_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ds(mem_ds), .mem_din(mem_din), .stall(stall), .mem_req_ack(mem_req_ack),
    .mem_dout(mem_dout), .busy(busy));

  toggle_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .mem_addr(addr_z), .mem_req(req_z), .mem_we(we_z),
    .mem_ds(ds_z), .mem_din(din_z), .stall(stall_z), .mem_req_ack(ack_z),
    .mem_dout(dout_z), .busy(busy_z));

  int checks = 0;
  int passed = 0;

  // Model: expected ack edge, busy window, pending op and a word-addressed memory.
  int          cyc = 0;
  bit          m_ack = 1'b0;
  logic [15:0] m_dout = 16'h0000;
  int          ack_at = -1, busy_from = -1, busy_to = -2, idle_from = 0;
  int          cur_e0 = -1, st_lo = 0, st_hi = -1;
  bit          p_we, p_oor;
  int          p_key;
  logic [1:0]  p_ds;
  logic [15:0] p_din;
  logic [15:0] mem_m [int];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    chk("ack", {15'b0, mem_req_ack}, {15'b0, m_ack});
    chk("busy", {15'b0, busy}, {15'b0, (cyc >= busy_from && cyc <= busy_to)});
    chk("dout", mem_dout, m_dout);
  end

  task automatic step();
    logic [15:0] old;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      m_ack = 1'b0; m_dout = 16'h0000; ack_at = -1;
      busy_from = -1; busy_to = -2; idle_from = cyc + 1;
    end else if (cyc == ack_at) begin
      m_ack = ~m_ack;
      old = mem_m.exists(p_key) ? mem_m[p_key] : 16'h0000;
      if (p_we) begin
        if (!p_oor) mem_m[p_key] = {p_ds[1] ? p_din[15:8] : old[15:8], p_ds[0] ? p_din[7:0] : old[7:0]};
      end else begin
        m_dout = p_oor ? 16'hFFFF : old;
      end
      ack_at = -1;
    end
    @(negedge clk);
    // Inputs are scrambled once the request is latched; they must have no effect.
    if (cyc == cur_e0) begin
      mem_din = ~mem_din; mem_addr = mem_addr ^ 22'h1; mem_ds = ~mem_ds; mem_we = ~mem_we;
    end
    stall = (cyc + 1 >= st_lo) && (cyc + 1 <= st_hi);
  endtask

  task automatic sched_req(bit we, logic [22:1] a, logic [1:0] ds, logic [15:0] d,
                           int st_off, int st_len, output int e0);
    e0 = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    ack_at = e0 + W + 2 + st_len;
    busy_from = e0; busy_to = ack_at - 1; idle_from = ack_at + 1;
    p_we = we; p_ds = ds; p_din = d;
    p_oor = (a >> AB) != 0;
    p_key = int'(a[AB:1]);
    cur_e0 = e0; st_lo = e0 + st_off; st_hi = st_lo + st_len - 1;
    mem_we = we; mem_addr = a; mem_ds = ds; mem_din = d;
    stall = 1'b0;
  endtask

  task automatic start_req(bit we, logic [22:1] a, logic [1:0] ds, logic [15:0] d,
                           int st_off, int st_len, output int e0);
    sched_req(we, a, ds, d, st_off, st_len, e0);
    mem_req = ~mem_req;
  endtask

  task automatic finish_req(string name, int e0, int exp_lat, bit is_rd, logic [15:0] exp_dat);
    int n = 0;
    while (mem_req_ack !== mem_req && n < 40) begin
      step();
      n++;
    end
    if (mem_req_ack !== mem_req) begin
      checks++;
      $display("FAIL %s_timeout: ack %b never matched req %b", name, mem_req_ack, mem_req);
    end else begin
      chk({name, "_lat"}, 16'(cyc - e0), 16'(exp_lat));
      if (is_rd) chk({name, "_rd"}, mem_dout, exp_dat);
    end
  endtask

  task automatic xfer(string name, bit we, logic [22:1] a, logic [1:0] ds, logic [15:0] d,
                      int st_off, int st_len, int exp_lat, logic [15:0] exp_dat);
    int e0;
    start_req(we, a, ds, d, st_off, st_len, e0);
    finish_req(name, e0, exp_lat, !we, exp_dat);
  endtask

  // Zero-wait instance: stall high for edges E0+1 .. E0+st_edges.
  task automatic z_req(string name, bit we, logic [22:1] a, logic [15:0] d, int st_edges,
                       int exp_n, logic [15:0] exp_dat);
    int n = 0;
    we_z = we; addr_z = a; din_z = d; ds_z = 2'b11; req_z = ~req_z;
    while (ack_z !== req_z && n < 20) begin
      step();
      n++;
      stall_z = (n <= st_edges);
      if (n == 2) chk({name, "_busy"}, {15'b0, busy_z}, 16'h0001);
    end
    stall_z = 1'b0;
    chk({name, "_edges"}, 16'(n), 16'(exp_n));
    if (!we) chk({name, "_rd"}, dout_z, exp_dat);
  endtask

  initial begin
    int e0;
    resetn = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_ds = 2'b00; mem_din = 16'h0;
    mem_addr = '0; stall = 1'b0;
    req_z = 1'b0; we_z = 1'b0; ds_z = 2'b00; din_z = 16'h0; addr_z = '0; stall_z = 1'b0;
    repeat (3) step();
    chk("rst_ack", {15'b0, mem_req_ack}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_dout", mem_dout, 16'h0);
    resetn = 1'b1;
    step();

    // Zero wait states, stall held in ACCESS for two edges.
    z_req("z_wr", 1'b1, 22'h000005, 16'hC0DE, 2, 5, 16'h0);
    step();
    z_req("z_rd", 1'b0, 22'h000005, 16'h0000, 0, 3, 16'hC0DE);
    step();

    xfer("wr10", 1'b1, 22'h000010, 2'b11, 16'h1234, 1, 0, 4, 16'h0);
    step();
    xfer("rd10", 1'b0, 22'h000010, 2'b11, 16'h0000, 1, 0, 4, 16'h1234);
    repeat (6) step();

    xfer("wr20a", 1'b1, 22'h000020, 2'b11, 16'hA5A5, 1, 0, 4, 16'h0);
    xfer("wr20b", 1'b1, 22'h000020, 2'b10, 16'h3C00, 1, 0, 4, 16'h0);
    xfer("wr20c", 1'b1, 22'h000020, 2'b00, 16'h00FF, 1, 0, 4, 16'h0);
    xfer("rd20", 1'b0, 22'h000020, 2'b01, 16'h0000, 1, 0, 4, 16'h3CA5);
    step();

    xfer("wr40_stw", 1'b1, 22'h000040, 2'b11, 16'h4242, 1, 3, 7, 16'h0);
    step();
    xfer("rd40_sta", 1'b0, 22'h000040, 2'b11, 16'h0000, 3, 2, 6, 16'h4242);
    step();

    xfer("wr_oor", 1'b1, 22'h200010, 2'b11, 16'h5555, 1, 0, 4, 16'h0);
    xfer("rd_oor", 1'b0, 22'h200010, 2'b11, 16'h0000, 1, 0, 4, 16'hFFFF);
    xfer("rd10b", 1'b0, 22'h000010, 2'b11, 16'h0000, 1, 0, 4, 16'h1234);

    // Back-to-back pairs: each new toggle lands right after the previous ack.
    xfer("wr100", 1'b1, 22'h000100, 2'b11, 16'hCAFE, 1, 0, 4, 16'h0);
    xfer("wr101", 1'b1, 22'h000101, 2'b11, 16'hF00D, 1, 0, 4, 16'h0);
    xfer("rd100", 1'b0, 22'h000100, 2'b11, 16'h0000, 1, 0, 4, 16'hCAFE);
    xfer("rd101", 1'b0, 22'h000101, 2'b11, 16'h0000, 1, 0, 4, 16'hF00D);
    step();

    // Reset in WAIT of a write; mem_req left at 1 so one read is served after release.
    xfer("wr30", 1'b1, 22'h000030, 2'b11, 16'h7777, 1, 0, 4, 16'h0);
    step();
    start_req(1'b1, 22'h000030, 2'b11, 16'hBEEF, 1, 0, e0);
    step();
    resetn = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 22'h000030; mem_ds = 2'b11;
    step();
    chk("mid_rst_ack", {15'b0, mem_req_ack}, 16'h0);
    chk("mid_rst_busy", {15'b0, busy}, 16'h0);
    chk("mid_rst_dout", mem_dout, 16'h0);
    step();
    resetn = 1'b1;
    sched_req(1'b0, 22'h000030, 2'b11, 16'h0000, 1, 0, e0);
    finish_req("rd30_post_rst", e0, 4, 1'b1, 16'h7777);
    repeat (8) step();
    chk("one_ack_only", {15'b0, mem_req_ack}, 16'h0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, %0d/%0d", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
